// File: rtl/minefield_board_if.sv
// rtl/minefield_board_if.sv - command channel and display read port of the minefield board
interface minefield_board_if;
  logic [3:0] gridCursorX;
  logic [3:0] gridCursorY;
  logic [6:0] gridElement;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [3:0] userCursorX;
  logic [3:0] userCursorY;

  // Requester side: input logic and display controller
  modport master (
    output gridCursorX, gridCursorY, cmd_valid, cmd_op, userCursorX, userCursorY,
    input  gridElement, cmd_ready
  );

  // Responder side: the board itself
  modport slave (
    input  gridCursorX, gridCursorY, cmd_valid, cmd_op, userCursorX, userCursorY,
    output gridElement, cmd_ready
  );
endinterface

// File: rtl/minefield_board.sv
// rtl/minefield_board.sv - Minesweeper cell store and rule engine; MINEFIELD_FLOOD_EN adds zero-cell flood reveal
module minefield_board #(
  parameter int          BOMB_COUNT = 40,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clock,
  input  logic              rst,
  minefield_board_if.slave  bus,
  input  logic [3:0]        gridWidth,
  input  logic [3:0]        gridHeight,
  input  logic              new_game,
  output logic [1:0]        status,
  output logic [8:0]        flag_count
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, PLACE, COUNT, PLAY, LOST, WON
`ifdef MINEFIELD_FLOOD_EN
    , FLOOD
`endif
  } state_t;

  localparam int          BOMB_CLAMP = (BOMB_COUNT > 256) ? 256 : ((BOMB_COUNT < 0) ? 0 : BOMB_COUNT);
  localparam logic [8:0]  BOMB_REQ   = BOMB_CLAMP[8:0];

  state_t      state, nextState;
  logic [15:0] lfsr;
  logic [3:0]  widthMax, heightMax;
  logic [255:0] bombV, uncV, flagV;
  logic [3:0]  cntV [256];
  logic        exploded;
  logic [7:0]  explIdx;
  logic [7:0]  scanIdx;
  logic [8:0]  placed, revealed, flagCnt;

  logic [8:0]  cells, bombTarget, safeCells;
  logic [7:0]  candIdx, cmdIdx, curIdx;
  logic        candIn, cmdIn, curIn;
  logic        cmdFire, revealFire, flagFire;
  logic [3:0]  nbrBombs;
`ifdef MINEFIELD_FLOOD_EN
  logic        floodChanged;
  logic        nbrZeroOpen;
  logic        scanIn;
  logic        floodHit;
`endif

  // Derived game geometry and command decode
  always_comb begin
    cells      = (9'(widthMax) + 9'd1) * (9'(heightMax) + 9'd1);
    bombTarget = (BOMB_REQ < cells) ? BOMB_REQ : (cells - 9'd1);
    safeCells  = cells - bombTarget;
    candIdx    = lfsr[7:0];
    candIn     = (lfsr[3:0] <= widthMax) && (lfsr[7:4] <= heightMax);
    cmdIdx     = {bus.userCursorY, bus.userCursorX};
    cmdIn      = (bus.userCursorX <= widthMax) && (bus.userCursorY <= heightMax);
    cmdFire    = (state == PLAY) && bus.cmd_valid && !new_game;
    revealFire = cmdFire && !bus.cmd_op && cmdIn && !flagV[cmdIdx] && !uncV[cmdIdx];
    flagFire   = cmdFire && bus.cmd_op && cmdIn && !uncV[cmdIdx];
  end

  // Neighbourhood of the sweep cell: bomb count, and (for flood) an open zero neighbour
  always_comb begin
    int nx, ny;
    logic [7:0] nIdx;
    nx = 0;
    ny = 0;
    nIdx = '0;
    nbrBombs = '0;
`ifdef MINEFIELD_FLOOD_EN
    nbrZeroOpen = 1'b0;
`endif
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(scanIdx[3:0]) + dx;
        ny = int'(scanIdx[7:4]) + dy;
        nIdx = 8'(ny * 16 + nx);
        if ((dx != 0 || dy != 0) && nx >= 0 && ny >= 0 &&
            nx <= int'(widthMax) && ny <= int'(heightMax)) begin
          if (bombV[nIdx]) nbrBombs = nbrBombs + 4'd1;
`ifdef MINEFIELD_FLOOD_EN
          if (uncV[nIdx] && cntV[nIdx] == 4'd0) nbrZeroOpen = 1'b1;
`endif
        end
      end
    end
  end

`ifdef MINEFIELD_FLOOD_EN
  // A sweep cell opens when it is a covered, unflagged, in-range safe cell touching an open zero
  always_comb begin
    scanIn   = (scanIdx[3:0] <= widthMax) && (scanIdx[7:4] <= heightMax);
    floodHit = (state == FLOOD) && scanIn && !uncV[scanIdx] && !flagV[scanIdx] &&
               !bombV[scanIdx] && nbrZeroOpen;
  end
`endif

  // LFSR free-runs from reset; a new game never reseeds it
  always_ff @(posedge clock or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  end

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state rules; new_game overrides everything
  always_comb begin
    nextState = state;
    if (new_game) begin
      nextState = CLEAR;
    end else begin
      case (state)
        CLEAR: if (scanIdx == 8'hFF) nextState = PLACE;
        PLACE: if (placed == bombTarget) nextState = COUNT;
        COUNT: if (scanIdx == 8'hFF) nextState = PLAY;
        PLAY: begin
          if (revealFire) begin
            if (bombV[cmdIdx]) nextState = LOST;
`ifdef MINEFIELD_FLOOD_EN
            else if (cntV[cmdIdx] == 4'd0) nextState = FLOOD;
`endif
            else if (revealed + 9'd1 == safeCells) nextState = WON;
          end
        end
`ifdef MINEFIELD_FLOOD_EN
        FLOOD: begin
          if (scanIdx == 8'hFF && !(floodChanged || floodHit))
            nextState = (revealed == safeCells) ? WON : PLAY;
        end
`endif
        default: nextState = state;
      endcase
    end
  end

  // Handshake and game status
  always_comb begin
    bus.cmd_ready = (state == PLAY);
    case (state)
      PLAY:    status = 2'b01;
`ifdef MINEFIELD_FLOOD_EN
      FLOOD:   status = 2'b01;
`endif
      LOST:    status = 2'b10;
      WON:     status = 2'b11;
      default: status = 2'b00;
    endcase
  end

  // Cell store, counters and sweep index
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      widthMax  <= '0;
      heightMax <= '0;
      bombV     <= '0;
      uncV      <= '0;
      flagV     <= '0;
      for (int i = 0; i < 256; i++) cntV[i] <= '0;
      exploded  <= 1'b0;
      explIdx   <= '0;
      scanIdx   <= '0;
      placed    <= '0;
      revealed  <= '0;
      flagCnt   <= '0;
`ifdef MINEFIELD_FLOOD_EN
      floodChanged <= 1'b0;
`endif
    end else if (new_game) begin
      widthMax  <= gridWidth;
      heightMax <= gridHeight;
      exploded  <= 1'b0;
      explIdx   <= '0;
      scanIdx   <= '0;
      placed    <= '0;
      revealed  <= '0;
      flagCnt   <= '0;
`ifdef MINEFIELD_FLOOD_EN
      floodChanged <= 1'b0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          bombV[scanIdx] <= 1'b0;
          uncV[scanIdx]  <= 1'b0;
          flagV[scanIdx] <= 1'b0;
          cntV[scanIdx]  <= '0;
          scanIdx        <= scanIdx + 8'd1;
        end
        PLACE: begin
          if (placed != bombTarget && candIn && !bombV[candIdx]) begin
            bombV[candIdx] <= 1'b1;
            placed         <= placed + 9'd1;
          end
        end
        COUNT: begin
          cntV[scanIdx] <= nbrBombs;
          scanIdx       <= scanIdx + 8'd1;
        end
        PLAY: begin
          if (flagFire) begin
            flagV[cmdIdx] <= !flagV[cmdIdx];
            flagCnt       <= flagV[cmdIdx] ? (flagCnt - 9'd1) : (flagCnt + 9'd1);
          end
          if (revealFire) begin
            uncV[cmdIdx] <= 1'b1;
            if (bombV[cmdIdx]) begin
              exploded <= 1'b1;
              explIdx  <= cmdIdx;
            end else begin
              revealed <= revealed + 9'd1;
            end
`ifdef MINEFIELD_FLOOD_EN
            scanIdx      <= '0;
            floodChanged <= 1'b0;
`endif
          end
        end
`ifdef MINEFIELD_FLOOD_EN
        FLOOD: begin
          if (floodHit) begin
            uncV[scanIdx] <= 1'b1;
            revealed      <= revealed + 9'd1;
          end
          floodChanged <= (scanIdx == 8'hFF) ? 1'b0 : (floodChanged | floodHit);
          scanIdx      <= scanIdx + 8'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Zero-latency display lookup
  always_comb begin
    curIdx = {bus.gridCursorY, bus.gridCursorX};
    curIn  = (bus.gridCursorX <= widthMax) && (bus.gridCursorY <= heightMax);
    if (!curIn)
      bus.gridElement = 7'h00;
    else if (exploded && curIdx == explIdx)
      bus.gridElement = 7'h7F;
    else
      bus.gridElement = {cntV[curIdx], flagV[curIdx], bombV[curIdx], uncV[curIdx]};
  end

  assign flag_count = flagCnt;

endmodule

// File: tb/tb_minefield_board.sv
// tb/tb_minefield_board.sv - randomized self-checking bench for minefield_board against a rule-level model
module tb_minefield_board;

`ifdef MINEFIELD_FLOOD_EN
  localparam bit FLOOD = 1'b1;
`else
  localparam bit FLOOD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       rst;
  logic [3:0] gw [2];
  logic [3:0] gh [2];
  logic       ng [2];
  wire  [1:0] stA, stB;
  wire  [8:0] fcA, fcB;

  int tests = 0;
  int fails = 0;

  minefield_board_if bifA();
  minefield_board_if bifB();

  minefield_board #(.BOMB_COUNT(3)) dutA (
    .clock(clock), .rst(rst), .bus(bifA), .gridWidth(gw[0]), .gridHeight(gh[0]),
    .new_game(ng[0]), .status(stA), .flag_count(fcA));

  minefield_board #(.BOMB_COUNT(1)) dutB (
    .clock(clock), .rst(rst), .bus(bifB), .gridWidth(gw[1]), .gridHeight(gh[1]),
    .new_game(ng[1]), .status(stB), .flag_count(fcB));

  always #5 clock = ~clock;

  // ---------------- model state ----------------
  int         mw, mh, mB;
  bit         mBomb [256];
  bit         mUnc  [256];
  bit         mFlag [256];
  int         mCnt  [256];
  bit         mExpl;
  int         mExplIdx;
  logic [1:0] mSt;
  int         mFc;
  logic [6:0] obs [256];

  // ---------------- DUT access ----------------
  function automatic logic [1:0] stOf(int d);
    return (d == 0) ? stA : stB;
  endfunction
  function automatic logic [8:0] fcOf(int d);
    return (d == 0) ? fcA : fcB;
  endfunction
  function automatic logic rdyOf(int d);
    return (d == 0) ? bifA.cmd_ready : bifB.cmd_ready;
  endfunction
  function automatic logic [6:0] elemOf(int d);
    return (d == 0) ? bifA.gridElement : bifB.gridElement;
  endfunction

  task automatic setCur(int d, int x, int y);
    if (d == 0) begin bifA.gridCursorX = 4'(x); bifA.gridCursorY = 4'(y); end
    else        begin bifB.gridCursorX = 4'(x); bifB.gridCursorY = 4'(y); end
  endtask

  task automatic setCmd(int d, logic v, logic op, int x, int y);
    if (d == 0) begin
      bifA.cmd_valid = v; bifA.cmd_op = op; bifA.userCursorX = 4'(x); bifA.userCursorY = 4'(y);
    end else begin
      bifB.cmd_valid = v; bifB.cmd_op = op; bifB.userCursorX = 4'(x); bifB.userCursorY = 4'(y);
    end
  endtask

  task automatic snapshot(int d);
    for (int i = 0; i < 256; i++) begin
      setCur(d, i % 16, i / 16);
      #1;
      obs[i] = elemOf(d);
    end
    @(negedge clock);
  endtask

  task automatic startGame(int d, int w, int h, output int setup);
    int cyc;
    @(negedge clock);
    gw[d] = 4'(w); gh[d] = 4'(h); ng[d] = 1'b1;
    @(negedge clock);
    ng[d] = 1'b0;
    cyc = 0;
    while (stOf(d) !== 2'b01 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    setup = cyc;
    mw = w; mh = h;
  endtask

  task automatic doCmd(int d, bit op, int x, int y, output int low);
    @(negedge clock);
    setCmd(d, 1'b1, op, x, y);
    @(negedge clock);
    setCmd(d, 1'b0, 1'b0, 0, 0);
    low = 0;
    while (rdyOf(d) === 1'b0 && stOf(d) === 2'b01 && low < 5000) begin
      @(negedge clock);
      low++;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit inR(int x, int y);
    return x >= 0 && y >= 0 && x <= mw && y <= mh;
  endfunction

  function automatic int nbrBombs(int x, int y);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && inR(x + dx, y + dy) && mBomb[(y + dy) * 16 + x + dx]) s++;
    return s;
  endfunction

  function automatic bit openZeroNbr(int x, int y);
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && inR(x + dx, y + dy) &&
            mUnc[(y + dy) * 16 + x + dx] && mCnt[(y + dy) * 16 + x + dx] == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int safeOpen();
    int s = 0;
    for (int i = 0; i < 256; i++) if (inR(i % 16, i / 16) && mUnc[i] && !mBomb[i]) s++;
    return s;
  endfunction

  function automatic logic [6:0] expElem(int i);
    if (!inR(i % 16, i / 16)) return 7'h00;
    if (mExpl && i == mExplIdx) return 7'h7F;
    return {4'(mCnt[i]), mFlag[i], mBomb[i], mUnc[i]};
  endfunction

  task automatic buildModel(int cap);
    int cells;
    cells = (mw + 1) * (mh + 1);
    mB = (cap < cells) ? cap : cells - 1;
    for (int i = 0; i < 256; i++) begin
      mBomb[i] = inR(i % 16, i / 16) && obs[i][1];
      mUnc[i] = 1'b0; mFlag[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mCnt[i] = inR(i % 16, i / 16) ? nbrBombs(i % 16, i / 16) : 0;
    mExpl = 1'b0; mExplIdx = 0; mSt = 2'b01; mFc = 0;
  endtask

  task automatic modelCmd(bit op, int x, int y, output bit flooded);
    int i, cells;
    bit ch;
    flooded = 1'b0;
    i = y * 16 + x;
    cells = (mw + 1) * (mh + 1);
    if (mSt != 2'b01 || !inR(x, y)) return;
    if (op) begin
      if (!mUnc[i]) begin
        mFlag[i] = !mFlag[i];
        mFc += mFlag[i] ? 1 : -1;
      end
      return;
    end
    if (mFlag[i] || mUnc[i]) return;
    mUnc[i] = 1'b1;
    if (mBomb[i]) begin
      mExpl = 1'b1; mExplIdx = i; mSt = 2'b10;
      return;
    end
    if (FLOOD && mCnt[i] == 0) begin
      flooded = 1'b1;
      do begin
        ch = 1'b0;
        for (int j = 0; j < 256; j++)
          if (inR(j % 16, j / 16) && !mUnc[j] && !mFlag[j] && !mBomb[j] && openZeroNbr(j % 16, j / 16)) begin
            mUnc[j] = 1'b1; ch = 1'b1;
          end
      end while (ch);
    end
    if (safeOpen() == cells - mB) mSt = 2'b11;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    tests++; if (stA !== 2'b00) begin fails++; $display("FAIL reset_status got %b want 00", stA); end
    tests++; if (bifA.cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", bifA.cmd_ready); end
    tests++; if (fcA !== 9'd0) begin fails++; $display("FAIL reset_flag_count got %0d want 0", fcA); end
    @(negedge clock);
    ng[0] = 1'b1; gw[0] = 4'd15; gh[0] = 4'd15;
    @(negedge clock);
    ng[0] = 1'b0;
    repeat (257) @(negedge clock);
    tests++; if (stA !== 2'b00) begin fails++; $display("FAIL setup_status got %b want 00", stA); end
    rst = 1'b1;
    @(negedge clock);
    tests++; if (stA !== 2'b00) begin fails++; $display("FAIL midplace_status got %b want 00", stA); end
    tests++; if (bifA.cmd_ready !== 1'b0) begin fails++; $display("FAIL midplace_ready got %b want 0", bifA.cmd_ready); end
    snapshot(0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (obs[i] !== 7'h00) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL midplace_cells got %0d nonzero cells want 0", bad); end
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_place_count();
    int setup, bombs, bad, first;
    startGame(0, 3, 3, setup);
    tests++; if (setup < 513 || setup >= 3000) begin fails++; $display("FAIL setup_cycles got %0d want >=513 and bounded", setup); end
    snapshot(0);
    buildModel(3);
    bombs = 0;
    for (int i = 0; i < 256; i++) if (inR(i % 16, i / 16) && obs[i][1]) bombs++;
    tests++; if (bombs != 3) begin fails++; $display("FAIL bomb_count got %0d want 3", bombs); end
    tests++; if (obs[4] !== 7'h00) begin fails++; $display("FAIL cursor_4_0 got %h want 00", obs[4]); end
    bad = 0; first = -1;
    for (int i = 0; i < 256; i++) if (obs[i] !== expElem(i)) begin bad++; if (first < 0) first = i; end
    tests++; if (bad != 0) begin fails++; $display("FAIL counts cell %0d got %h want %h (%0d bad)", first, obs[first], expElem(first), bad); end
  endtask

  task automatic test_flag();
    int x, y, i, low;
    bit fl;
    do begin x = $urandom_range(0, mw); y = $urandom_range(0, mh); end while (mBomb[y * 16 + x]);
    i = y * 16 + x;
    doCmd(0, 1'b1, x, y, low); modelCmd(1'b1, x, y, fl);
    snapshot(0);
    tests++; if (obs[i][2] !== 1'b1) begin fails++; $display("FAIL flag_set got %b want 1", obs[i][2]); end
    tests++; if (fcA !== 9'd1) begin fails++; $display("FAIL flag_count_1 got %0d want 1", fcA); end
    doCmd(0, 1'b0, x, y, low); modelCmd(1'b0, x, y, fl);
    snapshot(0);
    tests++; if (obs[i] !== expElem(i) || obs[i][0] !== 1'b0) begin fails++; $display("FAIL reveal_flagged got %h want %h", obs[i], expElem(i)); end
    doCmd(0, 1'b1, x, y, low); modelCmd(1'b1, x, y, fl);
    snapshot(0);
    tests++; if (obs[i][2] !== 1'b0) begin fails++; $display("FAIL flag_clear got %b want 0", obs[i][2]); end
    tests++; if (fcA !== 9'd0) begin fails++; $display("FAIL flag_count_0 got %0d want 0", fcA); end
  endtask

  task automatic test_bomb();
    int x, y, i, low, bad;
    bit fl;
    do begin x = $urandom_range(0, mw); y = $urandom_range(0, mh); end while (!mBomb[y * 16 + x]);
    i = y * 16 + x;
    doCmd(0, 1'b0, x, y, low); modelCmd(1'b0, x, y, fl);
    snapshot(0);
    tests++; if (obs[i] !== 7'h7F) begin fails++; $display("FAIL exploded_cell got %h want 7f", obs[i]); end
    tests++; if (stA !== 2'b10) begin fails++; $display("FAIL lost_status got %b want 10", stA); end
    tests++; if (bifA.cmd_ready !== 1'b0) begin fails++; $display("FAIL lost_ready got %b want 0", bifA.cmd_ready); end
    for (int k = 0; k < 4; k++) begin
      x = $urandom_range(0, mw); y = $urandom_range(0, mh);
      doCmd(0, k[0], x, y, low); modelCmd(k[0], x, y, fl);
    end
    snapshot(0);
    bad = 0;
    for (int j = 0; j < 256; j++) if (obs[j] !== expElem(j)) bad++;
    tests++; if (bad != 0 || stA !== 2'b10 || fcA !== 9'd0) begin fails++; $display("FAIL after_lost got %0d bad cells status %b flags %0d want 0 10 0", bad, stA, fcA); end
  endtask

  task automatic test_small_grid();
    int setup, bombs, x, y, low;
    bit fl;
    startGame(0, 1, 1, setup);
    snapshot(0);
    buildModel(3);
    bombs = 0;
    for (int i = 0; i < 256; i++) if (inR(i % 16, i / 16) && obs[i][1]) bombs++;
    tests++; if (bombs != 3) begin fails++; $display("FAIL small_bombs got %0d want 3", bombs); end
    x = 0; y = 0;
    for (int i = 0; i < 4; i++) if (!mBomb[(i / 2) * 16 + i % 2]) begin x = i % 2; y = i / 2; end
    doCmd(0, 1'b0, x, y, low); modelCmd(1'b0, x, y, fl);
    tests++; if (stA !== 2'b11 || mSt !== 2'b11) begin fails++; $display("FAIL small_won got %b want 11", stA); end
  endtask

  task automatic test_new_game();
    int setup, low;
    bit fl;
    startGame(0, 5, 5, setup);
    snapshot(0);
    buildModel(3);
    doCmd(0, 1'b1, 2, 2, low); modelCmd(1'b1, 2, 2, fl);
    tests++; if (fcA !== 9'(mFc)) begin fails++; $display("FAIL pre_restart_flags got %0d want %0d", fcA, mFc); end
    @(negedge clock);
    ng[0] = 1'b1; setCmd(0, 1'b1, 1'b1, 3, 3);
    @(negedge clock);
    ng[0] = 1'b0; setCmd(0, 1'b0, 1'b0, 0, 0);
    tests++; if (stA !== 2'b00 || bifA.cmd_ready !== 1'b0 || fcA !== 9'd0) begin fails++; $display("FAIL restart got status %b ready %b flags %0d want 00 0 0", stA, bifA.cmd_ready, fcA); end
  endtask

  task automatic test_flood();
    int setup, x, y, low, bad, open;
    bit fl, okLow;
    startGame(1, 3, 3, setup);
    snapshot(1);
    buildModel(1);
    x = 0; y = 0;
    for (int i = 0; i < 16; i++) if (!mBomb[(i / 4) * 16 + i % 4] && mCnt[(i / 4) * 16 + i % 4] == 0) begin x = i % 4; y = i / 4; end
    doCmd(1, 1'b0, x, y, low); modelCmd(1'b0, x, y, fl);
    okLow = FLOOD ? (low >= 512 && low % 256 == 0 && low < 5000) : (low == 0);
    tests++; if (!okLow) begin fails++; $display("FAIL flood_busy got %0d cycles want %s", low, FLOOD ? ">=512 multiple of 256" : "0"); end
    snapshot(1);
    bad = 0; open = 0;
    for (int i = 0; i < 256; i++) begin
      if (obs[i] !== expElem(i)) bad++;
      if (inR(i % 16, i / 16) && obs[i][0]) open++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL flood_board got %0d bad cells want 0", bad); end
    tests++; if (open != (FLOOD ? 15 : 1)) begin fails++; $display("FAIL flood_open got %0d want %0d", open, FLOOD ? 15 : 1); end
    tests++; if (stB !== mSt) begin fails++; $display("FAIL flood_status got %b want %b", stB, mSt); end
  endtask

  task automatic test_random_play();
    int d, setup, x, y, low, bad, first, k;
    bit op, fl, okLow;
    for (int g = 0; g < 3; g++) begin
      d = g % 2;
      startGame(d, $urandom_range(1, 7), $urandom_range(1, 7), setup);
      tests++; if (setup >= 3000) begin fails++; $display("FAIL rand_setup got %0d want <3000", setup); end
      snapshot(d);
      buildModel(d == 0 ? 3 : 1);
      k = 0;
      while (mSt == 2'b01 && k < 60) begin
        x = $urandom_range(0, (mw < 15) ? mw + 1 : 15);
        y = $urandom_range(0, (mh < 15) ? mh + 1 : 15);
        op = ($urandom_range(0, 3) == 0);
        if (inR(x, y) && mBomb[y * 16 + x]) op = 1'b1;
        doCmd(d, op, x, y, low); modelCmd(op, x, y, fl);
        okLow = fl ? (low >= 512 && low % 256 == 0 && low < 5000) : (low == 0);
        tests++; if (!okLow) begin fails++; $display("FAIL rand_busy g%0d cmd%0d got %0d cycles", g, k, low); end
        snapshot(d);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) if (obs[i] !== expElem(i)) begin if (bad == 0) first = i; bad++; end
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_board g%0d cmd%0d cell %0d got %h want %h", g, k, first, obs[first], expElem(first)); end
        tests++; if (stOf(d) !== mSt || fcOf(d) !== 9'(mFc)) begin fails++; $display("FAIL rand_status g%0d cmd%0d got %b/%0d want %b/%0d", g, k, stOf(d), fcOf(d), mSt, mFc); end
        k++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      gw[d] = '0; gh[d] = '0; ng[d] = 1'b0;
      setCmd(d, 1'b0, 1'b0, 0, 0);
      setCur(d, 0, 0);
    end
    repeat (3) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    test_reset();
    test_place_count();
    test_flag();
    test_bomb();
    test_small_grid();
    test_new_game();
    test_flood();
    test_random_play();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
